// File: rtl/ring_ilk_pkg.sv
// Shared types and constants for the ring interlock route scheduler.
// Route state encoding, default conflict map and counter sizing.
package ring_ilk_pkg;

  localparam int NUM_ROUTES = 8;
  localparam int RR_PTR_W = 3;

  // Byte i is the conflict row of route i: adjacent ring segments.
  localparam logic [63:0] DEFAULT_CONFLICT =
    64'h41A0_5028_140A_0582;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_SETTING   = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_RELEASING = 2'd3
  } route_st_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/ring_route_rr_arb.sv
// Combinational round-robin picker: first eligible index at or
// after the pointer, wrapping, returned one-hot and as an index.
module ring_route_rr_arb
  import ring_ilk_pkg::*;
(
  input  logic [NUM_ROUTES-1:0] i_elig,
  input  logic [RR_PTR_W-1:0]   i_ptr,
  output logic [NUM_ROUTES-1:0] o_gnt,
  output logic [RR_PTR_W-1:0]   o_idx,
  output logic                  o_valid
);

  logic                found;
  logic [RR_PTR_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 0; k < NUM_ROUTES; k++) begin
      idx = i_ptr + RR_PTR_W'(k);
      if (!found && i_elig[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_idx      = idx;
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/ring_route_scheduler.sv
// Route-setting controller for the 8-route ring interlock:
// request latch, RR grant, timed setting and gated release.
module ring_route_scheduler
  import ring_ilk_pkg::*;
#(
  parameter int          NUM_ROUTES = 8,
  parameter int          SET_CYCLES = 4,
  parameter int          REL_CYCLES = 3,
  parameter logic [63:0] CONFLICT   = DEFAULT_CONFLICT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_ROUTES-1:0] i_req,
  input  logic [NUM_ROUTES-1:0] i_release,
  input  logic [NUM_ROUTES-1:0] i_occupied,
  output logic [NUM_ROUTES-1:0] o_pending,
  output logic [NUM_ROUTES-1:0] o_set,
  output logic [NUM_ROUTES-1:0] o_locked,
  output logic [NUM_ROUTES-1:0] o_active,
  output logic                  o_busy,
  output logic                  o_conflict_err
);

  localparam int CW = cnt_w(max2(SET_CYCLES, REL_CYCLES));
  localparam int PW = RR_PTR_W;

  route_st_e st_q  [NUM_ROUTES];
  route_st_e st_d  [NUM_ROUTES];
  logic [CW-1:0] cnt_q [NUM_ROUTES];
  logic [CW-1:0] cnt_d [NUM_ROUTES];

  logic [NUM_ROUTES-1:0] pend_q, pend_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  err_q, err_d;

  logic [NUM_ROUTES-1:0] free_v, set_v, lock_v, act_v;
  logic [NUM_ROUTES-1:0] set_done, blocked, elig;
  logic [NUM_ROUTES-1:0] arb_gnt, grant;
  logic [PW-1:0]         arb_idx;
  logic                  arb_valid, busy_hold, gnt_ok;
  logic                  clash;

  always_comb begin
    for (int i = 0; i < NUM_ROUTES; i++) begin
      free_v[i]   = (st_q[i] == ST_FREE);
      set_v[i]    = (st_q[i] == ST_SETTING);
      lock_v[i]   = (st_q[i] == ST_LOCKED);
      act_v[i]    = !free_v[i];
      set_done[i] = set_v[i] && (cnt_q[i] == CW'(1));
    end
  end

  always_comb begin
    blocked = '0;
    clash   = 1'b0;
    for (int i = 0; i < NUM_ROUTES; i++) begin
      for (int j = 0; j < NUM_ROUTES; j++) begin
        if (i != j && CONFLICT[NUM_ROUTES*i+j] && act_v[j]) begin
          blocked[i] = 1'b1;
          if (act_v[i]) clash = 1'b1;
        end
      end
    end
  end

  // A route finishing SETTING this edge frees the setter for a new grant.
  assign busy_hold = |(set_v & ~set_done);
  assign elig      = pend_q & free_v & ~blocked;

  ring_route_rr_arb u_arb (
    .i_elig  (elig),
    .i_ptr   (ptr_q),
    .o_gnt   (arb_gnt),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  assign gnt_ok = arb_valid && !busy_hold;
  assign grant  = gnt_ok ? arb_gnt : '0;

  always_comb begin
    for (int i = 0; i < NUM_ROUTES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        ST_FREE: begin
          if (grant[i]) begin
            st_d[i]  = ST_SETTING;
            cnt_d[i] = CW'(SET_CYCLES);
          end
        end
        ST_SETTING: begin
          if (cnt_q[i] == CW'(1)) begin
            st_d[i]  = ST_LOCKED;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        ST_LOCKED: begin
          if (i_release[i]) begin
            st_d[i]  = ST_RELEASING;
            cnt_d[i] = CW'(REL_CYCLES);
          end
        end
        ST_RELEASING: begin
          if (!i_occupied[i]) begin
            if (cnt_q[i] == CW'(1)) begin
              st_d[i]  = ST_FREE;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
        end
        default: begin
          st_d[i]  = ST_FREE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    pend_d = (pend_q | (i_req & free_v)) & ~grant;
    ptr_d  = gnt_ok ? (arb_idx + PW'(1)) : ptr_q;
    err_d  = err_q | clash;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_ROUTES; i++) begin
        st_q[i]  <= ST_FREE;
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ROUTES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  assign o_pending      = pend_q;
  assign o_set          = set_v;
  assign o_locked       = lock_v;
  assign o_active       = act_v;
  assign o_busy         = |set_v;
  assign o_conflict_err = err_q;

endmodule

// File: tb/tb_ring_route_scheduler.sv
// Scoreboard bench for ring_route_scheduler: expected output
// snapshots are queued per edge and popped as the DUT advances.
module tb_ring_route_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] rel = '0;
  logic [7:0] occ = '0;
  logic [7:0] o_pending, o_set, o_locked, o_active;
  logic       o_busy, o_conflict_err;

  logic [32:0] got;
  logic [32:0] e;
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  ring_route_scheduler dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_release      (rel),
    .i_occupied     (occ),
    .o_pending      (o_pending),
    .o_set          (o_set),
    .o_locked       (o_locked),
    .o_active       (o_active),
    .o_busy         (o_busy),
    .o_conflict_err (o_conflict_err)
  );

  always #5 clk = ~clk;

  assign got = {o_busy, o_pending, o_set, o_locked, o_active};

  // busy is derived from the expected setting vector
  function automatic void push(input logic [7:0] p, input logic [7:0] s,
                               input logic [7:0] l, input logic [7:0] a);
    exp_q.push_back({|s, p, s, l, a});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; rel = '0; occ = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    push(8'h00, 8'h00, 8'h00, 8'h00);
    push(8'h00, 8'h01, 8'h00, 8'h01);
    push(8'h00, 8'h00, 8'h00, 8'h00);
    push(8'h00, 8'h00, 8'h00, 8'h00);
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h", got, e);
    end
    req = 8'h01; step(); req = '0; step();
    e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_pre: got %h want %h", got, e);
    end
    #3 rst_n = 1'b0;
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (got !== e || o_conflict_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got %h err %b want %h err 0",
               got, o_conflict_err, e);
    end
    step(); rst_n = 1'b1; step();
    e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_after: got %h want %h", got, e);
    end
  endtask

  task automatic test_single();
    do_reset();
    push(8'h10, 8'h00, 8'h00, 8'h00);
    repeat (4) push(8'h00, 8'h10, 8'h00, 8'h10);
    push(8'h00, 8'h00, 8'h10, 8'h10);
    for (int k = 0; k < 6; k++) begin
      req = (k == 0) ? 8'h10 : 8'h00;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL single[e%0d]: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_conflict();
    push(8'h29, 8'h00, 8'h10, 8'h10);
    repeat (4) push(8'h28, 8'h01, 8'h10, 8'h11);
    push(8'h28, 8'h00, 8'h11, 8'h11);
    repeat (3) push(8'h28, 8'h00, 8'h01, 8'h11);
    push(8'h28, 8'h00, 8'h01, 8'h01);
    repeat (4) push(8'h20, 8'h08, 8'h01, 8'h09);
    repeat (4) push(8'h00, 8'h20, 8'h09, 8'h29);
    push(8'h00, 8'h00, 8'h29, 8'h29);
    for (int k = 0; k < 19; k++) begin
      req = (k == 0) ? 8'h29 : 8'h00;
      rel = (k == 6) ? 8'h10 : 8'h00;
      occ = '0;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL conflict[e%0d]: got %h want %h", k, got, e);
      end
    end
    rel = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(8'h05, 8'h00, 8'h00, 8'h00);
    repeat (4) push(8'h04, 8'h01, 8'h00, 8'h01);
    repeat (4) push(8'h00, 8'h04, 8'h01, 8'h05);
    push(8'h00, 8'h00, 8'h05, 8'h05);
    for (int k = 0; k < 10; k++) begin
      req = (k == 0) ? 8'h05 : 8'h00;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL b2b[e%0d]: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_occupancy();
    do_reset();
    push(8'h04, 8'h00, 8'h00, 8'h00);
    repeat (4) push(8'h00, 8'h04, 8'h00, 8'h04);
    push(8'h00, 8'h00, 8'h04, 8'h04);
    push(8'h02, 8'h00, 8'h04, 8'h04);
    repeat (7) push(8'h02, 8'h00, 8'h00, 8'h04);
    push(8'h02, 8'h00, 8'h00, 8'h00);
    push(8'h00, 8'h02, 8'h00, 8'h02);
    for (int k = 0; k < 16; k++) begin
      req = (k == 0) ? 8'h04 : (k == 6) ? 8'h02 : 8'h00;
      rel = (k == 7) ? 8'h04 : 8'h00;
      occ = (k >= 7 && k <= 11) ? 8'h04 : 8'h00;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL occupancy[e%0d]: got %h want %h", k, got, e);
      end
    end
    occ = '0;
  endtask

  task automatic test_ignored();
    do_reset();
    push(8'h40, 8'h00, 8'h00, 8'h00);
    repeat (4) push(8'h00, 8'h40, 8'h00, 8'h40);
    repeat (3) push(8'h00, 8'h00, 8'h40, 8'h40);
    for (int k = 0; k < 8; k++) begin
      req = (k == 0 || k == 6) ? 8'h40 : 8'h00;
      rel = (k == 2) ? 8'h40 : 8'h00;
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL ignored[e%0d]: got %h want %h", k, got, e);
      end
    end
    req = '0; rel = '0;
    n_cmp++;
    if (o_conflict_err !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_err: got %b want 0", o_conflict_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    n_cmp++;
    if (o_conflict_err !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_err_mid: got %b want 0", o_conflict_err);
    end
    test_back_to_back();
    test_occupancy();
    n_cmp++;
    if (o_conflict_err !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_err_occ: got %b want 0", o_conflict_err);
    end
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_route_scheduler.md
Name: ring_route_scheduler

Overview:
Sequential route-setting controller for the 8-route ring interlock (routes A..H = index 0..7).
- Latches route requests, arbitrates them round-robin and grants a route only when no conflicting route is active.
- Times the shared point-setting resource (one route setting at a time), then holds the route locked until a timed, occupancy-gated release.
- Its outputs drive the combinational per-route interlock equations and the signal lamps.

Parameters:
NUM_ROUTES, 8, number of routes; fixed at 8 in this revision.
SET_CYCLES, 4, cycles o_set[i] stays high while points move; must be >= 1.
REL_CYCLES, 3, unoccupied cycles required before a released route is freed; must be >= 1.
CONFLICT, 64'h41A0_5028_140A_0582, bit [8*i+j]=1 means route i conflicts with route j; must be symmetric; diagonal ignored. Default: adjacent ring segments conflict (i with i±1 mod 8).

Ports:
i_clk  in  1  single clock; all state on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_req  in  8  request pulse per route; sets pending[i]
i_release  in  8  release pulse per route
i_occupied  in  8  track-occupied per route, synchronous to i_clk
o_pending  out  8  latched, not-yet-granted requests
o_set  out  8  route i is setting (points moving)
o_locked  out  8  route i locked, signal may clear
o_active  out  8  route i not FREE (SETTING, LOCKED or RELEASING)
o_busy  out  1  some route is SETTING
o_conflict_err  out  1  sticky; two conflicting routes active at once

Behaviour:
- Reset (async assert, any state): all routes FREE, pending=0, counters=0, RR pointer=0, o_conflict_err=0. Every output reads 0 immediately. Synchronous deassert is assumed upstream.
- Per-route FSM:
  - FREE -> SETTING on grant.
  - SETTING -> LOCKED after SET_CYCLES cycles in SETTING.
  - LOCKED -> RELEASING on i_release[i].
  - RELEASING -> FREE when the release counter expires.
- Outputs: o_set[i]=(SETTING), o_locked[i]=(LOCKED), o_active[i]=(state!=FREE).
- Pending:
  - i_req[i] sets pending[i] only when route i is FREE; otherwise the pulse is ignored.
  - A grant clears pending[i] on the same edge; pending set and grant never coincide for the same route.
- Eligibility: pending[i] & FREE & no j with CONFLICT[8*i+j] & active[j].
- Grant:
  - At most one grant per edge, and only while no route is SETTING (o_busy=0).
  - Winner is the first eligible index at or after the RR pointer, wrapping 7->0.
  - Pointer then becomes winner+1 mod 8.
  - A route leaving SETTING on edge t lets a new grant occur on edge t (back-to-back).
- Latency:
  - i_req sampled on edge t sets pending. If eligible and idle, grant on edge t+1.
  - o_set high after edges t+1..t+SET_CYCLES. o_locked rises after edge t+1+SET_CYCLES.
- Release:
  - i_release[i] is ignored unless route i is LOCKED.
  - RELEASING loads counter=REL_CYCLES. The counter decrements each cycle i_occupied[i]=0 and holds while i_occupied[i]=1.
  - At 1 with occupancy clear, the route goes to FREE.
  - o_locked drops on the edge that samples the release.
- i_req or i_release for a route in SETTING: ignored; the route completes SETTING regardless.
- Counters are $clog2(max+1) bits and never wrap.
- o_conflict_err: set on any edge where conflicting routes are both active; cleared only by reset. This is an internal consistency alarm and must never assert in legal operation.

Decomposition:
- Package ring_ilk_pkg: NUM_ROUTES, route-state enum (FREE/SETTING/LOCKED/RELEASING), DEFAULT_CONFLICT constant, counter width functions.
- One sub-module ring_route_rr_arb: combinational 8-way round-robin picker (eligible vector + pointer -> one-hot grant + valid).

Test Plan:
1. Reset: assert i_rst_n=0 mid-operation -> all outputs 0 with no clock edge; after release all routes FREE.
2. Single route (SET=4, REL=3): i_req[4] pulse at edge 0 -> o_pending[4] after e0; o_set[4]=1 after e1..e4; o_locked[4]=1 after e5.
3. Conflict hold: route 4 LOCKED; pulse i_req[3], i_req[5], i_req[0] together -> 0 granted; 3 and 5 stay pending until route 4 FREE, then granted 3 before 5 (pointer dependent, check value).
4. Round-robin/back-to-back: after reset, i_req[0] and i_req[2] together -> route 0 SETTING 4 cycles; route 2 SETTING starts on the same edge route 0 goes LOCKED.
5. Occupancy release: route 2 LOCKED, i_release[2] with i_occupied[2]=1 for 5 cycles -> o_locked[2]=0 next edge, o_active[2] stays 1 until 3 unoccupied cycles elapse; pending route 1 is granted the following edge.
6. Ignored pulses: i_release[6] while route 6 SETTING and i_req[6] while LOCKED -> no state change; o_conflict_err stays 0 throughout all tests.
